// File: rtl/aes_defs.sv
// Shared AES definitions for the cipher datapath.
// Contents: GF(2^8) reduction constant, state and column widths,
// the xtime helper and the state encoding of the InvMixColumns unit.
package aes_defs;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int unsigned STATE_W  = 128;
    localparam int unsigned COL_W    = 32;

    typedef enum logic [1:0] {
        IMC_IDLE = 2'd0,
        IMC_BUSY = 2'd1,
        IMC_DONE = 2'd2
    } imc_state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_col.sv
// Combinational InvMixColumns for a single 32-bit column.
// Ports:
//   x0..x3  input  8  column bytes, row 0..3
//   y0..y3  output 8  transformed column bytes, row 0..3
module inv_mix_col
    import aes_defs::*;
(
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic [7:0] x3,
    output logic [7:0] y0,
    output logic [7:0] y1,
    output logic [7:0] y2,
    output logic [7:0] y3
);

    // Products by 09/0B/0D/0E share the x2/x4/x8 xtime chain.
    typedef struct packed {
        logic [7:0] m9;
        logic [7:0] mb;
        logic [7:0] md;
        logic [7:0] me;
    } prod_t;

    function automatic prod_t products(input logic [7:0] b);
        logic [7:0] b2;
        logic [7:0] b4;
        logic [7:0] b8;
        prod_t      p;
        b2   = xtime(b);
        b4   = xtime(b2);
        b8   = xtime(b4);
        p.m9 = b8 ^ b;
        p.mb = b8 ^ b2 ^ b;
        p.md = b8 ^ b4 ^ b;
        p.me = b8 ^ b4 ^ b2;
        return p;
    endfunction

    prod_t p0;
    prod_t p1;
    prod_t p2;
    prod_t p3;

    always_comb begin
        p0 = products(x0);
        p1 = products(x1);
        p2 = products(x2);
        p3 = products(x3);
        y0 = p0.me ^ p1.mb ^ p2.md ^ p3.m9;
        y1 = p0.m9 ^ p1.me ^ p2.mb ^ p3.md;
        y2 = p0.md ^ p1.m9 ^ p2.me ^ p3.mb;
        y3 = p0.mb ^ p1.md ^ p2.m9 ^ p3.me;
    end

endmodule

// File: rtl/inv_mix_cols.sv
// Iterative AES InvMixColumns: accepts a 128-bit state, transforms one
// column per clock through a single shared column unit, then presents
// the result until downstream takes it.
// Ports:
//   clk        input   1    rising-edge clock
//   rst_n      input   1    asynchronous active-low reset
//   in_valid   input   1    in_state is valid
//   in_ready   output  1    block can accept a state this cycle
//   in_state   input   128  byte 0 = [127:120] .. byte 15 = [7:0]
//   out_valid  output  1    out_state holds a finished result
//   out_ready  input   1    downstream accepts out_state
//   out_state  output  128  InvMixColumns(in_state), same byte order
module inv_mix_cols
    import aes_defs::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);

    imc_state_t         state;
    logic [1:0]         col;
    logic [STATE_W-1:0] st;
    logic [COL_W-1:0]   col_in;
    logic [COL_W-1:0]   col_out;
    logic [STATE_W-1:0] st_wb;

    // Column c occupies bits [127-32c -: 32], row 0 in the top byte.
    always_comb begin
        col_in = '0;
        case (col)
            2'd0: col_in = st[127:96];
            2'd1: col_in = st[95:64];
            2'd2: col_in = st[63:32];
            2'd3: col_in = st[31:0];
            default: col_in = '0;
        endcase
    end

    inv_mix_col u_col (
        .x0(col_in[31:24]),
        .x1(col_in[23:16]),
        .x2(col_in[15:8]),
        .x3(col_in[7:0]),
        .y0(col_out[31:24]),
        .y1(col_out[23:16]),
        .y2(col_out[15:8]),
        .y3(col_out[7:0])
    );

    always_comb begin
        st_wb = st;
        case (col)
            2'd0: st_wb[127:96] = col_out;
            2'd1: st_wb[95:64]  = col_out;
            2'd2: st_wb[63:32]  = col_out;
            2'd3: st_wb[31:0]   = col_out;
            default: st_wb = st;
        endcase
    end

    // Only DONE lets out_ready reach in_ready, so a new state can be
    // accepted in the same cycle the previous result is consumed.
    assign in_ready  = (state == IMC_IDLE) | ((state == IMC_DONE) & out_ready);
    assign out_state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IMC_IDLE;
            col       <= '0;
            st        <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IMC_IDLE: begin
                    if (in_valid) begin
                        st    <= in_state;
                        col   <= '0;
                        state <= IMC_BUSY;
                    end
                end
                IMC_BUSY: begin
                    st  <= st_wb;
                    col <= col + 2'd1;
                    if (col == 2'd3) begin
                        state     <= IMC_DONE;
                        out_valid <= 1'b1;
                    end
                end
                IMC_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            st    <= in_state;
                            col   <= '0;
                            state <= IMC_BUSY;
                        end else begin
                            state <= IMC_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IMC_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_cols.sv
module tb_inv_mix_cols;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    int unsigned total;
    int unsigned bad;

    inv_mix_cols dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_state(in_state),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_state(out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: generic GF(2^8) matrix product
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
        end
        return p;
    endfunction

    // Circulant matrix product applied to every column; row r uses
    // row_coef rotated right by r.
    function automatic logic [127:0] mix_state(input logic [127:0] s, input logic [31:0] row_coef);
        logic [7:0]   cf [4];
        logic [7:0]   x  [4];
        logic [7:0]   y;
        logic [127:0] res;
        cf[0] = row_coef[31:24];
        cf[1] = row_coef[23:16];
        cf[2] = row_coef[15:8];
        cf[3] = row_coef[7:0];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) x[r] = s[127 - 8*(4*c + r) -: 8];
            for (int r = 0; r < 4; r++) begin
                y = 8'h00;
                for (int k = 0; k < 4; k++) y = y ^ gmul(x[k], cf[(k - r + 4) % 4]);
                res[127 - 8*(4*c + r) -: 8] = y;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        return mix_state(s, 32'h0E0B0D09);
    endfunction

    function automatic logic [127:0] ref_fwd(input logic [127:0] s);
        return mix_state(s, 32'h02030101);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Send one state with out_ready high; returns result and the number
    // of edges from the accept edge to out_valid.
    task automatic run_one(input logic [127:0] s, output logic [127:0] r, output int lat);
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = s;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;          // accept edge
        in_valid = 1'b0;
        in_state = rand128();         // must be ignored during BUSY
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("in_ready_busy", {127'd0, in_ready}, 128'd0);
            @(posedge clk); #1;
            lat++;
        end
        r = out_state;
        @(posedge clk); #1;          // output handshake
    endtask

    logic [127:0] r;
    logic [127:0] s;
    logic [127:0] exp_st;
    int           lat;
    logic [31:0]  col_vec_in  [4];
    logic [31:0]  col_vec_out [4];

    logic [127:0] b2b_in  [3];
    logic [127:0] b2b_out [$];
    int           acc_cyc [$];
    int           out_cyc [$];

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_in_ready",  {127'd0, in_ready},  128'd1);
        check("rst_out_state", out_state, 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // single-column vectors in column 0
        col_vec_in[0] = 32'h8e4da1bc; col_vec_out[0] = 32'hdb135345;
        col_vec_in[1] = 32'h9fdc589d; col_vec_out[1] = 32'hf20a225c;
        col_vec_in[2] = 32'h4d7ebdf8; col_vec_out[2] = 32'h2d26314c;
        col_vec_in[3] = 32'hd5d5d7d6; col_vec_out[3] = 32'hd4d4d4d5;
        for (int i = 0; i < 4; i++) begin
            run_one({col_vec_in[i], 96'd0}, r, lat);
            check("col_vec", r, {col_vec_out[i], 96'd0});
        end

        // full state and latency
        run_one(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, r, lat);
        check("full_state", r, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
        check("latency", lat, 128'd4);
        check("idle_after", {126'd0, out_valid, in_ready}, 128'd1);

        // backpressure
        s = rand128();
        exp_st = ref_inv(s);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("bp_latency", lat, 128'd4);
        in_valid = 1'b1;              // competing state must not be taken
        in_state = rand128();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", {127'd0, out_valid}, 128'd1);
            check("bp_state", out_state, exp_st);
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;
        check("bp_consumed_once", {127'd0, out_valid}, 128'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_no_repeat", {127'd0, out_valid}, 128'd0);
        end

        // back-to-back, in_valid held high
        for (int i = 0; i < 3; i++) b2b_in[i] = rand128();
        begin
            int idx;
            int cyc;
            logic hs_in;
            logic hs_out;
            idx = 0;
            cyc = 0;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_state  = b2b_in[0];
            while (b2b_out.size() < 3 && cyc < 60) begin
                @(negedge clk);
                hs_in  = in_valid & in_ready;
                hs_out = out_valid & out_ready;
                if (hs_in)  acc_cyc.push_back(cyc);
                if (hs_out) begin
                    out_cyc.push_back(cyc);
                    b2b_out.push_back(out_state);
                end
                @(posedge clk); #1;
                if (hs_in) begin
                    idx++;
                    if (idx < 3) in_state = b2b_in[idx];
                    else in_valid = 1'b0;
                end
                cyc++;
            end
        end
        check("b2b_count", b2b_out.size(), 128'd3);
        check("b2b_acc_count", acc_cyc.size(), 128'd3);
        for (int i = 0; i < 3; i++)
            if (i < b2b_out.size()) check("b2b_data", b2b_out[i], ref_inv(b2b_in[i]));
        for (int i = 1; i < 3; i++)
            if (i < acc_cyc.size()) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 128'd5);
        for (int i = 0; i < 2; i++)
            if (i + 1 < acc_cyc.size() && i < out_cyc.size())
                check("b2b_overlap", acc_cyc[i+1], out_cyc[i]);
        @(posedge clk); #1;

        // reset during BUSY
        in_valid = 1'b1;
        in_state = rand128();
        @(posedge clk); #1;           // accept edge T
        in_valid = 1'b0;
        @(posedge clk);               // T+1
        @(posedge clk);               // T+2
        rst_n = 1'b0;
        #1;
        check("rstb_out_valid", {127'd0, out_valid}, 128'd0);
        check("rstb_in_ready",  {127'd0, in_ready},  128'd1);
        check("rstb_out_state", out_state, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("rstb_no_spurious", {127'd0, out_valid}, 128'd0);
        end
        run_one({4{32'h01010101}}, r, lat);
        check("rstb_next", r, {4{32'h01010101}});
        check("rstb_latency", lat, 128'd4);

        // round trip with forward MixColumns
        for (int i = 0; i < 1000; i++) begin
            s = rand128();
            run_one(ref_fwd(s), r, lat);
            check("round_trip", r, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/inv_mix_cols.md
# inv_mix_cols

Iterative AES InvMixColumns unit for the decryption datapath. It takes a full 128-bit AES state over a valid/ready handshake and transforms one 32-bit column per clock. It returns the result over a second valid/ready handshake. It is the decrypt-side counterpart of the combinational forward MixColumns column logic and sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse round.

## Interface
Parameters: none. Byte order, polynomial and coefficients are fixed constants.

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  `in_state` is valid
- in_ready  output  1  block can accept a state this cycle
- in_state  input  128  input state; byte 0 = [127:120] … byte 15 = [7:0]; column c = bytes 4c..4c+3, row 0 in the most significant byte
- out_valid  output  1  `out_state` holds a finished result
- out_ready  input  1  downstream accepts `out_state`
- out_state  output  128  InvMixColumns(`in_state`), same byte order

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - BUSY: column counter `col`[1:0] steps 0→3.
  - DONE: `out_valid`=1.
- Accept: when `in_valid & in_ready`, latch `in_state` into the working register `st`, set `col`=0 and go to BUSY.
- BUSY, each cycle:
  - Replace column `col` of `st` with its InvMixColumns value.
  - `col` increments.
  - At `col`==3, go to DONE after the write.
- Column math, with x0..x3 = rows 0..3 and all operations in GF(2^8) mod x^8+x^4+x^3+x+1 (reduction 8'h1B):
  - y0 = 0E·x0 ^ 0B·x1 ^ 0D·x2 ^ 09·x3
  - y1 = 09·x0 ^ 0E·x1 ^ 0B·x2 ^ 0D·x3
  - y2 = 0D·x0 ^ 09·x1 ^ 0E·x2 ^ 0B·x3
  - y3 = 0B·x0 ^ 0D·x1 ^ 09·x2 ^ 0E·x3
- Multiplies are built from repeated xtime; all intermediates stay 8 bits.
- DONE:
  - `out_state` = `st`, held stable while `out_valid`=1 and `out_ready`=0.
  - On `out_valid & out_ready`, go to IDLE. If `in_valid` is also high that cycle, accept the new state and go straight to BUSY.
  - `in_ready` = IDLE | (DONE & `out_ready`).
- `in_state` is ignored outside an accept cycle. Changing it during BUSY has no effect.

## Timing
- Reset values (asynchronous, immediate): FSM=IDLE, `col`=0, `st`=0, `in_ready`=1, `out_valid`=0, `out_state`=0.
- Latency: accept at edge T; columns written at edges T+1..T+4; `out_valid`=1 from T+4. Four cycles accept-to-valid.
- Throughput: one state per 5 cycles with `out_ready` held high.
- Backpressure: DONE holds indefinitely. No data is lost or overwritten.
- Reset asserted mid-BUSY or mid-DONE:
  - Result is discarded and everything returns to reset values.
  - After deassertion, the first accept is a clean new operation.
- `out_valid` never depends combinationally on `out_ready`. `in_ready` depends combinationally on `out_ready` only in DONE.

## Structure
- Shared include/package `aes_defs`: `AES_POLY`=8'h1B, `xtime` function, state width 128, column width 32.
- Sub-module `inv_mix_col` (combinational, one column): inputs x0..x3, outputs y0..y3. It is instantiated once and fed by a 4:1 column mux on `col`.
- The top level holds the FSM, `col`, `st`, and the column write-back demux.

## Test plan
- Single column vectors, checked in column 0 with the remaining columns 0: 8e4da1bc→db135345, 9fdc589d→f20a225c, 4d7ebdf8→2d26314c, d5d5d7d6→d4d4d4d5.
- Full state and latency:
  - Stimulus: `in_state`=8e4da1bc_9fdc589d_01010101_c6c6c6c6, `out_ready`=1.
  - Response: `out_state`=db135345_f20a225c_01010101_c6c6c6c6, `out_valid` rising exactly 4 cycles after the accept edge, `in_ready` low during BUSY.
- Backpressure: hold `out_ready`=0 for 10 cycles → `out_valid` and `out_state` stay stable and `in_ready`=(0) until `out_ready`=1. The state is then consumed exactly once.
- Back-to-back:
  - Stimulus: `in_valid` held high with 3 states, `out_ready`=1.
  - Response: accepts every 5 cycles, a new accept in the same cycle as each output handshake, correct outputs in order.
- Reset during BUSY: assert `rst_n`=0 at edge T+2.
  - Response: `out_valid`=0 and `in_ready`=1 immediately, no spurious output afterwards.
  - Next state 01010101×4 → 01010101×4.
- Round trip with the forward MixColumns block on 1000 random states → output equals input.
